// File: rtl/block_serializer_gearbox_if.sv
// Block-in / beat-out bus of the PHY transmit gearbox, plus its status flags.
interface block_serializer_gearbox_if #(
  parameter int BLOCK_W = 130,
  parameter int OUT_W   = 1
);
  logic [BLOCK_W-1:0] in_data;
  logic               in_valid;
  logic               in_ready;
  logic [OUT_W-1:0]   out_data;
  logic               out_valid;
  logic               out_ready;
  logic               out_last;
  logic               busy;
  logic               underrun;

  // Both sides: a transfer happens on a rising clk edge where valid && ready;
  // valid never waits on ready, and data is held stable while valid && !ready.
  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid, out_last, busy, underrun
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid, out_last, busy, underrun
  );
endinterface

// File: rtl/block_serializer_gearbox.sv
// Parallel-to-serial gearbox: BLOCK_W-bit blocks out as OUT_W-bit beats, with a
// one-entry hold register so consecutive blocks stream without a bubble.
module block_serializer_gearbox #(
  parameter int BLOCK_W   = 130,
  parameter int OUT_W     = 1,
  parameter bit LSB_FIRST = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  block_serializer_gearbox_if.slave  bus
);
  localparam int BEATS = BLOCK_W / OUT_W;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  generate
    if (BLOCK_W % OUT_W != 0) begin : g_bad_ratio
      $error("block_serializer_gearbox: BLOCK_W must be a multiple of OUT_W");
    end
  endgenerate

  logic [BLOCK_W-1:0] r_shift;
  logic [BLOCK_W-1:0] r_hold;
  logic               r_active_full;
  logic               r_hold_full;
  logic [CW-1:0]      r_beat_cnt;
  logic               r_underrun;

  logic               w_in_acc;
  logic               w_out_acc;
  logic               w_last;
  logic               w_reload;
  logic [BLOCK_W-1:0] w_shifted;

  assign w_in_acc  = bus.in_valid && !r_hold_full;
  assign w_out_acc = r_active_full && bus.out_ready;
  assign w_last    = (r_beat_cnt == CW'(BEATS - 1));
  // Active register is refilled when empty or as its final beat leaves.
  assign w_reload  = !r_active_full || (w_out_acc && w_last);

  always_comb begin
    w_shifted = r_shift;
    if (LSB_FIRST) w_shifted = r_shift >> OUT_W;
    else           w_shifted = r_shift << OUT_W;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift       <= '0;
      r_hold        <= '0;
      r_active_full <= 1'b0;
      r_hold_full   <= 1'b0;
      r_beat_cnt    <= '0;
      r_underrun    <= 1'b0;
    end else begin
      r_underrun <= w_out_acc && w_last && !r_hold_full && !w_in_acc;
      if (w_reload) begin
        r_beat_cnt <= '0;
        if (r_hold_full) begin
          r_shift       <= r_hold;
          r_active_full <= 1'b1;
          r_hold_full   <= 1'b0;
        end else if (w_in_acc) begin
          // Bypass straight into active; hold stays empty.
          r_shift       <= bus.in_data;
          r_active_full <= 1'b1;
        end else begin
          r_active_full <= 1'b0;
        end
      end else begin
        if (w_out_acc) begin
          r_shift    <= w_shifted;
          r_beat_cnt <= r_beat_cnt + CW'(1);
        end
        if (w_in_acc) begin
          r_hold      <= bus.in_data;
          r_hold_full <= 1'b1;
        end
      end
    end
  end

  assign bus.in_ready  = !r_hold_full;
  assign bus.out_valid = r_active_full;
  assign bus.out_data  = LSB_FIRST ? r_shift[OUT_W-1:0] : r_shift[BLOCK_W-1 -: OUT_W];
  assign bus.out_last  = r_active_full && w_last;
  assign bus.busy      = r_active_full || r_hold_full;
  assign bus.underrun  = r_underrun;
endmodule

// File: doc/block_serializer_gearbox.md
Name: block_serializer_gearbox

Overview:
Parametrised parallel-to-serial gearbox for the PHY transmit path. It converts BLOCK_W-bit blocks (default 130b, for 128b/130b) into OUT_W-bit beats, with valid/ready handshakes on both sides. A one-entry holding buffer lets back-to-back blocks stream with no idle cycle between them. Bit order is selectable as MSB-first or LSB-first.

Parameters:
BLOCK_W, 130, input block width in bits.
OUT_W, 1, output beat width in bits. BLOCK_W % OUT_W must equal 0; otherwise elaboration fails.
LSB_FIRST, 0, 0 = transmit block MSB first, 1 = transmit LSB first.

Ports:
clk  in  1  clock; all logic on rising edge.
rst_n  in  1  asynchronous active-low reset.
in_data  in  BLOCK_W  parallel block.
in_valid  in  1  in_data is valid.
in_ready  out  1  block can be accepted; equals !hold_full (registered state).
out_data  out  OUT_W  current beat.
out_valid  out  1  out_data is valid.
out_ready  in  1  downstream accepts the beat.
out_last  out  1  out_valid && beat_cnt == BEATS-1.
busy  out  1  active block or held block present.
underrun  out  1  one-cycle pulse: last beat taken and no next block available.

Behaviour:
- BEATS = BLOCK_W/OUT_W. beat_cnt width is $clog2(BEATS) (minimum 1).
- Reset (async, rst_n low) sets:
  - out_valid=0, out_data=0, out_last=0, busy=0, underrun=0.
  - hold_full=0, so in_ready=1; active_full=0; beat_cnt=0.
- Storage:
  - active shift register (active_full flag) and hold register (hold_full flag).
  - in_acc = in_valid && in_ready. out_acc = out_valid && out_ready.
- out_valid = active_full. out_data is driven directly from the active register:
  - LSB_FIRST=0: out_data = shift[BLOCK_W-1 -: OUT_W]; the register shifts left by OUT_W on out_acc.
  - LSB_FIRST=1: out_data = shift[OUT_W-1:0]; the register shifts right by OUT_W on out_acc.
  - Shift fill value is 0.
- On out_acc with beat_cnt < BEATS-1: shift, beat_cnt+1.
- Active reload happens when active is empty, or on out_acc with out_last. Source priority:
  - (a) hold register, if hold_full. Clear hold_full.
  - (b) in_data, if in_acc this cycle (bypass; hold stays empty).
  - (c) otherwise active_full=0.
  - Any reload sets beat_cnt=0.
- If in_acc and the block does not go to active (active still busy, or hold already moving into active), in_data is written to hold and hold_full=1.
- Hold write and hold-to-active move can occur in the same cycle only if hold is empty beforehand. in_ready=0 while hold is full, so no overwrite is possible.
- Latency: idle block accepted at edge t gives its first beat on out_valid in the cycle after t. No bubble between blocks if the next block is held or presented on the last beat.
- underrun is registered and asserted the cycle after out_acc && out_last when reload source is (c).
- out_ready low: out_data, beat_cnt and shift hold stable. in_acc into hold is still allowed.
- busy = active_full || hold_full.
- Mid-operation reset: all state is discarded immediately. Partial blocks are never resumed.
- OUT_W == BLOCK_W: BEATS=1; every beat is out_last.

Test Plan:
1. BLOCK_W=130, OUT_W=10, MSB-first; out_ready=1; single block 130'h2_AAAA…5555.
   - out_valid rises 1 cycle after accept.
   - 13 beats, MSB chunk first; out_last on beat 13.
   - underrun pulses 1 cycle later; busy falls.
2. Same config; 4 blocks offered continuously with in_valid=1.
   - 52 consecutive out_valid cycles, no gaps.
   - in_ready drops while hold is full.
   - Data matches each block in order; no underrun until after block 4.
3. out_ready toggled pseudo-randomly 50%.
   - Each beat is held stable until accepted.
   - Reassembled blocks equal inputs; beat count is exactly 13 per block.
4. LSB_FIRST=1, OUT_W=1, block = 130'h1.
   - First beat = 1, next 129 beats = 0.
   - LSB_FIRST=0 with the same block: 129 zeros then 1.
5. Assert rst_n low at beat 6 of block 1 while hold is full.
   - All outputs immediately reach reset values; in_ready=1.
   - New block after reset streams from beat 0.
6. OUT_W=130 (BEATS=1); blocks offered each cycle with out_ready=1.
   - One beat per cycle with out_last=1.
   - Sustained throughput of 1 block/cycle.
